// File: rtl/vga_timing_if.sv
// Raster-timing bundle: pixel coordinates and qualifiers for the colour
// generators, plus the sync and blanking signals for the video DAC.
interface vga_timing_if;
  logic [10:0] x;
  logic [10:0] y;
  logic        disp_en;
  logic        frame_start;
  logic        line_start;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic        VGA_SYNC_N;

  // Timing generator side
  modport master (
    output x, y, disp_en, frame_start, line_start,
    output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
  );

  // Consumer side (pixel generators, DAC)
  modport slave (
    input x, y, disp_en, frame_start, line_start,
    input VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
  );
endinterface

// File: rtl/vga_timing.sv
// Raster timing generator (1280x1024@60 by default). Produces registered
// x/y counters with coherent disp_en/frame_start/line_start, and DAC-side
// sync/blanking delayed by SYNC_DLY cycles to match registered colour.
module vga_timing #(
  parameter int H        = 1280,
  parameter int HFP      = 48,
  parameter int HS       = 112,
  parameter int HBP      = 248,
  parameter int V        = 1024,
  parameter int VFP      = 1,
  parameter int VS       = 3,
  parameter int VBP      = 38,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int SYNC_DLY = 1
) (
  input  logic         VGA_CLK,
  input  logic         reset,
  vga_timing_if.master vga_o
);

  localparam int HTOT = H + HFP + HS + HBP;
  localparam int VTOT = V + VFP + VS + VBP;

  localparam logic [10:0] X_LAST = 11'(HTOT - 1);
  localparam logic [10:0] Y_LAST = 11'(VTOT - 1);
  localparam logic [10:0] X_VIS  = 11'(H);
  localparam logic [10:0] Y_VIS  = 11'(V);
  localparam logic [10:0] HS_BEG = 11'(H + HFP);
  localparam logic [10:0] HS_END = 11'(H + HFP + HS);
  localparam logic [10:0] VS_BEG = 11'(V + VFP);
  localparam logic [10:0] VS_END = 11'(V + VFP + VS);

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        de_q, de_d;
  logic        fs_q, fs_d;
  logic        ls_q, ls_d;
  logic        raw_hs_d, raw_vs_d;

  // Stage 0 is aligned with x/y; stage SYNC_DLY drives the DAC pins.
  logic        hs_dly_q  [0:SYNC_DLY];
  logic        vs_dly_q  [0:SYNC_DLY];
  logic        vld_dly_q [0:SYNC_DLY];

  // Next counter values: x free-runs, y advances on the x wrap.
  always_comb begin
    x_d = x_q + 11'd1;
    y_d = y_q;
    if (x_q == X_LAST) begin
      x_d = 11'd0;
      if (y_q == Y_LAST) begin
        y_d = 11'd0;
      end else begin
        y_d = y_q + 11'd1;
      end
    end
  end

  // Flags and raw (active-high) syncs decoded from the next counter values,
  // so once registered they are coherent with x/y in the same cycle.
  always_comb begin
    de_d     = (x_d < X_VIS) && (y_d < Y_VIS);
    ls_d     = (x_d == 11'd0);
    fs_d     = (x_d == 11'd0) && (y_d == 11'd0);
    raw_hs_d = (x_d >= HS_BEG) && (x_d < HS_END);
    raw_vs_d = (y_d >= VS_BEG) && (y_d < VS_END);
  end

  // Counter and flag registers; reset parks the raster on its last pixel so
  // the first released edge lands on (0,0).
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      x_q  <= X_LAST;
      y_q  <= Y_LAST;
      de_q <= 1'b0;
      fs_q <= 1'b0;
      ls_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      de_q <= de_d;
      fs_q <= fs_d;
      ls_q <= ls_d;
    end
  end

  // DAC-side delay line: stage 0 loads alongside x/y, later stages shift.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      for (int i = 0; i <= SYNC_DLY; i++) begin
        hs_dly_q[i]  <= 1'b0;
        vs_dly_q[i]  <= 1'b0;
        vld_dly_q[i] <= 1'b0;
      end
    end else begin
      hs_dly_q[0]  <= raw_hs_d;
      vs_dly_q[0]  <= raw_vs_d;
      vld_dly_q[0] <= de_d;
      for (int i = 1; i <= SYNC_DLY; i++) begin
        hs_dly_q[i]  <= hs_dly_q[i-1];
        vs_dly_q[i]  <= vs_dly_q[i-1];
        vld_dly_q[i] <= vld_dly_q[i-1];
      end
    end
  end

  assign vga_o.x           = x_q;
  assign vga_o.y           = y_q;
  assign vga_o.disp_en     = de_q;
  assign vga_o.frame_start = fs_q;
  assign vga_o.line_start  = ls_q;
  // Polarity is applied only at the pins; the delay line stays active-high.
  assign vga_o.VGA_HS      = hs_dly_q[SYNC_DLY] ^ ~HS_POL;
  assign vga_o.VGA_VS      = vs_dly_q[SYNC_DLY] ^ ~VS_POL;
  assign vga_o.VGA_BLANK_N = vld_dly_q[SYNC_DLY];
  // No sync-on-green.
  assign vga_o.VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing: three instances (full 1280x1024 timing, and two
// shrunken rasters sweeping SYNC_DLY/polarity) checked every cycle against a
// behavioural raster model through a per-instance expectation queue.
module tb_vga_timing;

  // Shrunken raster: HTOT = 28, VTOT = 11, frame = 308 cycles.
  localparam int SH = 16, SHFP = 2, SHS = 4, SHBP = 6;
  localparam int SV = 6,  SVFP = 1, SVS = 2, SVBP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_if if0 ();
  vga_timing_if ifa ();
  vga_timing_if ifb ();

  vga_timing u_dut0 (.VGA_CLK(clk), .reset(rst), .vga_o(if0.master));

  vga_timing #(
    .H(SH), .HFP(SHFP), .HS(SHS), .HBP(SHBP),
    .V(SV), .VFP(SVFP), .VS(SVS), .VBP(SVBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .SYNC_DLY(0)
  ) u_duta (.VGA_CLK(clk), .reset(rst), .vga_o(ifa.master));

  vga_timing #(
    .H(SH), .HFP(SHFP), .HS(SHS), .HBP(SHBP),
    .V(SV), .VFP(SVFP), .VS(SVS), .VBP(SVBP),
    .HS_POL(1'b0), .VS_POL(1'b1), .SYNC_DLY(3)
  ) u_dutb (.VGA_CLK(clk), .reset(rst), .vga_o(ifb.master));

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        de;
    logic        fs;
    logic        ls;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        sn;
  } exp_t;

  // Model parameters per instance: 0 = full timing, 1 = A, 2 = B.
  int P_H   [3] = '{1280, SH,   SH};
  int P_HFP [3] = '{48,   SHFP, SHFP};
  int P_HS  [3] = '{112,  SHS,  SHS};
  int P_HBP [3] = '{248,  SHBP, SHBP};
  int P_V   [3] = '{1024, SV,   SV};
  int P_VFP [3] = '{1,    SVFP, SVFP};
  int P_VS  [3] = '{3,    SVS,  SVS};
  int P_VBP [3] = '{38,   SVBP, SVBP};
  int P_DLY [3] = '{1,    0,    3};
  int P_HPL [3] = '{1,    0,    0};
  int P_VPL [3] = '{1,    0,    1};

  int mx [3];
  int my [3];
  bit hh [3][4];
  bit hv [3][4];
  bit hd [3][4];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Behavioural raster for instance k across the coming edge; pushes the
  // outputs that edge must produce.
  task automatic model_push(input int k, input bit r);
    exp_t e;
    int htot, vtot, d;
    htot = P_H[k] + P_HFP[k] + P_HS[k] + P_HBP[k];
    vtot = P_V[k] + P_VFP[k] + P_VS[k] + P_VBP[k];
    d    = P_DLY[k];
    e    = '0;
    if (r) begin
      mx[k] = htot - 1;
      my[k] = vtot - 1;
      for (int i = 0; i < 4; i++) begin
        hh[k][i] = 1'b0;
        hv[k][i] = 1'b0;
        hd[k][i] = 1'b0;
      end
    end else begin
      if (mx[k] == htot - 1) begin
        mx[k] = 0;
        my[k] = (my[k] == vtot - 1) ? 0 : my[k] + 1;
      end else begin
        mx[k] = mx[k] + 1;
      end
      e.de = (mx[k] < P_H[k]) && (my[k] < P_V[k]);
      e.ls = (mx[k] == 0);
      e.fs = (mx[k] == 0) && (my[k] == 0);
      for (int i = 3; i > 0; i--) begin
        hh[k][i] = hh[k][i-1];
        hv[k][i] = hv[k][i-1];
        hd[k][i] = hd[k][i-1];
      end
      hh[k][0] = (mx[k] >= P_H[k] + P_HFP[k]) && (mx[k] < P_H[k] + P_HFP[k] + P_HS[k]);
      hv[k][0] = (my[k] >= P_V[k] + P_VFP[k]) && (my[k] < P_V[k] + P_VFP[k] + P_VS[k]);
      hd[k][0] = e.de;
    end
    e.x  = 11'(mx[k]);
    e.y  = 11'(my[k]);
    e.hs = (P_HPL[k] != 0) ? hh[k][d] : ~hh[k][d];
    e.vs = (P_VPL[k] != 0) ? hv[k][d] : ~hv[k][d];
    e.bn = hd[k][d];
    e.sn = 1'b0;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic exp_t obs(input int k);
    exp_t o;
    case (k)
      0: begin
        o.x = if0.x; o.y = if0.y; o.de = if0.disp_en; o.fs = if0.frame_start;
        o.ls = if0.line_start; o.hs = if0.VGA_HS; o.vs = if0.VGA_VS;
        o.bn = if0.VGA_BLANK_N; o.sn = if0.VGA_SYNC_N;
      end
      1: begin
        o.x = ifa.x; o.y = ifa.y; o.de = ifa.disp_en; o.fs = ifa.frame_start;
        o.ls = ifa.line_start; o.hs = ifa.VGA_HS; o.vs = ifa.VGA_VS;
        o.bn = ifa.VGA_BLANK_N; o.sn = ifa.VGA_SYNC_N;
      end
      default: begin
        o.x = ifb.x; o.y = ifb.y; o.de = ifb.disp_en; o.fs = ifb.frame_start;
        o.ls = ifb.line_start; o.hs = ifb.VGA_HS; o.vs = ifb.VGA_VS;
        o.bn = ifb.VGA_BLANK_N; o.sn = ifb.VGA_SYNC_N;
      end
    endcase
    return o;
  endfunction

  task automatic sb_compare(input int k);
    exp_t e, o;
    bit   have;
    string p;
    have = 1'b1;
    e    = '0;
    case (k)
      0:       if (q0.size() == 0) have = 1'b0; else e = q0.pop_front();
      1:       if (q1.size() == 0) have = 1'b0; else e = q1.pop_front();
      default: if (q2.size() == 0) have = 1'b0; else e = q2.pop_front();
    endcase
    p = $sformatf("d%0d", k);
    if (!have) begin
      chk({p, ".sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    o = obs(k);
    chk({p, ".x"},           32'(o.x),  32'(e.x));
    chk({p, ".y"},           32'(o.y),  32'(e.y));
    chk({p, ".disp_en"},     32'(o.de), 32'(e.de));
    chk({p, ".frame_start"}, 32'(o.fs), 32'(e.fs));
    chk({p, ".line_start"},  32'(o.ls), 32'(e.ls));
    chk({p, ".VGA_HS"},      32'(o.hs), 32'(e.hs));
    chk({p, ".VGA_VS"},      32'(o.vs), 32'(e.vs));
    chk({p, ".VGA_BLANK_N"}, 32'(o.bn), 32'(e.bn));
    chk({p, ".VGA_SYNC_N"},  32'(o.sn), 32'(e.sn));
  endtask

  // One clock: drive reset, queue expectations, sample after the edge.
  task automatic tick(input bit r);
    @(negedge clk);
    rst = r;
    for (int k = 0; k < 3; k++) model_push(k, r);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) sb_compare(k);
  endtask

  // Free-running statistics gathered over the uninterrupted first phase.
  int de0_cnt   = 0;
  int hs0_first = -1;
  int hs0_last  = -1;
  int prev0_x   = 1687;
  int prev0_y   = 1065;
  bit wrap_seen = 1'b0;
  int last_fs_a = -1;
  int fs_gaps   = 0;
  int vs_run_a  = 0;
  int vs_pulses = 0;
  int hs_run_b  = 0;
  int hs_pulses = 0;
  bit prev_fs_a = 1'b0;

  task automatic stats();
    if (if0.y == 11'd0 && if0.disp_en) de0_cnt++;
    if (if0.y == 11'd0 && if0.VGA_HS) begin
      if (hs0_first < 0) hs0_first = int'(if0.x);
      hs0_last = int'(if0.x);
    end
    if (if0.x == 11'd0 && if0.y == 11'd1) begin
      wrap_seen = 1'b1;
      chk("d0.wrap_prev_x", 32'(prev0_x), 32'd1687);
      chk("d0.wrap_prev_y", 32'(prev0_y), 32'd0);
    end
    prev0_x = int'(if0.x);
    prev0_y = int'(if0.y);

    if (ifa.frame_start) begin
      chk("A.fs_implies_ls", 32'(ifa.line_start), 32'd1);
      chk("A.fs_not_back_to_back", 32'(prev_fs_a), 32'd0);
      if (last_fs_a >= 0) begin
        chk("A.frame_period", 32'(cyc - last_fs_a), 32'd308);
        fs_gaps++;
      end
      last_fs_a = cyc;
    end
    prev_fs_a = ifa.frame_start;

    if (ifa.VGA_VS == 1'b0) begin
      if (vs_run_a == 0) begin
        chk("A.vs_start_y", 32'(ifa.y), 32'd7);
        chk("A.vs_start_x", 32'(ifa.x), 32'd0);
      end
      vs_run_a++;
    end else if (vs_run_a > 0) begin
      chk("A.vs_width", 32'(vs_run_a), 32'd56);
      vs_pulses++;
      vs_run_a = 0;
    end

    if (ifb.VGA_HS == 1'b0) begin
      hs_run_b++;
    end else if (hs_run_b > 0) begin
      chk("B.hs_width", 32'(hs_run_b), 32'd4);
      hs_pulses++;
      hs_run_b = 0;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mx[k] = 0;
      my[k] = 0;
      for (int i = 0; i < 4; i++) begin
        hh[k][i] = 1'b0;
        hv[k][i] = 1'b0;
        hd[k][i] = 1'b0;
      end
    end

    // Reset state
    repeat (3) tick(1'b1);
    chk("rst.x",       32'(if0.x), 32'd1687);
    chk("rst.y",       32'(if0.y), 32'd1065);
    chk("rst.disp_en", 32'(if0.disp_en), 32'd0);
    chk("rst.blank_n", 32'(if0.VGA_BLANK_N), 32'd0);
    chk("rst.hs",      32'(if0.VGA_HS), 32'd0);
    chk("rst.vs",      32'(if0.VGA_VS), 32'd0);
    chk("rst.b_hs",    32'(ifb.VGA_HS), 32'd1);

    // First released edge lands on (0,0) with all flags up
    tick(1'b0);
    chk("rel.x",  32'(if0.x), 32'd0);
    chk("rel.y",  32'(if0.y), 32'd0);
    chk("rel.de", 32'(if0.disp_en), 32'd1);
    chk("rel.fs", 32'(if0.frame_start), 32'd1);
    chk("rel.ls", 32'(if0.line_start), 32'd1);
    last_fs_a = cyc;
    prev_fs_a = 1'b1;
    stats_dummy_skip: begin end
    tick(1'b0);
    chk("rel2.x",  32'(if0.x), 32'd1);
    chk("rel2.fs", 32'(if0.frame_start), 32'd0);
    chk("rel2.ls", 32'(if0.line_start), 32'd0);
    prev_fs_a = 1'b0;
    de0_cnt   = 2;
    prev0_x   = 1;
    prev0_y   = 0;

    // One full line of the full-size raster, several small frames
    repeat (1700) begin
      tick(1'b0);
      stats();
    end
    chk("d0.line_de_cycles", 32'(de0_cnt), 32'd1280);
    chk("d0.hs_first_x",     32'(hs0_first), 32'd1329);
    chk("d0.hs_last_x",      32'(hs0_last), 32'd1440);
    chk("d0.wrap_seen",      32'(wrap_seen), 32'd1);
    chk("A.frame_gaps_seen", 32'(fs_gaps > 2), 32'd1);
    chk("A.vs_pulses_seen",  32'(vs_pulses > 2), 32'd1);
    chk("B.hs_pulses_seen",  32'(hs_pulses > 20), 32'd1);

    // Mid-frame resets at arbitrary points, including a two-cycle hold
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(20, 400)) tick(1'b0);
      tick(1'b1);
      if (n == 2) tick(1'b1);
      chk("mid_rst.x",       32'(if0.x), 32'd1687);
      chk("mid_rst.y",       32'(if0.y), 32'd1065);
      chk("mid_rst.blank_n", 32'(if0.VGA_BLANK_N), 32'd0);
      chk("mid_rst.hs",      32'(if0.VGA_HS), 32'd0);
      chk("mid_rst.vs",      32'(if0.VGA_VS), 32'd0);
      tick(1'b0);
      chk("mid_rel.x", 32'(if0.x), 32'd0);
      chk("mid_rel.y", 32'(if0.y), 32'd0);
    end
    repeat (320) tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
